// File: rtl/fp_pkg.sv
// ============================================================================
// Module      : fp_pkg
// Description : Shared IEEE-754 single-precision constants and converter FSM
//               state encoding for the fixed/float converter group.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 127;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ABS   = 3'd1,
        S_NORM  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_e;

endpackage : fp_pkg

`default_nettype wire

// File: rtl/fp_round_pack.sv
// ============================================================================
// Module      : fp_round_pack
// Description : Round-to-nearest-even and pack of a normalized magnitude into
//               an IEEE-754 single word (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_round_pack
    import fp_pkg::*;
(
    input  logic        sign_i,
    input  logic [8:0]  exp_i,
    input  logic [30:0] mag_i,     // bits below the hidden leading one
    output logic [31:0] data_o,
    output logic        inexact_o
);

    logic [FP_MAN_W-1:0] w_man;
    logic                w_guard;
    logic                w_sticky;
    logic                w_round_up;
    logic [FP_MAN_W:0]   w_man_sum;
    logic [8:0]          w_exp_adj;
    logic                w_unused_exp_msb;

    assign w_man      = mag_i[30:8];
    assign w_guard    = mag_i[7];
    assign w_sticky   = |mag_i[6:0];
    assign w_round_up = w_guard & (w_sticky | w_man[0]);

    // An all-ones mantissa that rounds up carries out; the carry bumps the
    // exponent and leaves the low mantissa bits at zero.
    assign w_man_sum  = {1'b0, w_man} + {{FP_MAN_W{1'b0}}, w_round_up};
    assign w_exp_adj  = exp_i + {8'b0, w_man_sum[FP_MAN_W]};

    assign data_o     = {sign_i, w_exp_adj[FP_EXP_W-1:0], w_man_sum[FP_MAN_W-1:0]};
    assign inexact_o  = w_guard | w_sticky;

    assign w_unused_exp_msb = w_exp_adj[8];

endmodule : fp_round_pack

`default_nettype wire

// File: rtl/fixed_to_fp.sv
// ============================================================================
// Module      : fixed_to_fp
// Description : Signed Q(32-FRAC).FRAC fixed-point to IEEE-754 single, one
//               normalization bit per cycle, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_to_fp
    import fp_pkg::*;
#(
    parameter int XLEN = 32,    // only 32 is supported
    parameter int FRAC = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_inexact
);

    localparam logic [8:0] C_EXP_BASE = 9'(FP_BIAS + XLEN - 1 - FRAC);

    state_e          state_q, state_d;
    logic            sign_q, sign_d;
    logic [XLEN-1:0] mag_q, mag_d;
    logic [4:0]      shift_q, shift_d;
    logic            zero_q, zero_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            inexact_q, inexact_d;

    logic [8:0]      w_exp;
    logic [XLEN-1:0] w_pack_data;
    logic            w_pack_inexact;

    assign w_exp = C_EXP_BASE - {4'b0, shift_q};

    fp_round_pack u_round_pack (
        .sign_i    (sign_q),
        .exp_i     (w_exp),
        .mag_i     (mag_q[XLEN-2:0]),
        .data_o    (w_pack_data),
        .inexact_o (w_pack_inexact)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            shift_q   <= '0;
            zero_q    <= 1'b0;
            data_q    <= '0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            shift_q   <= shift_d;
            zero_q    <= zero_d;
            data_q    <= data_d;
            inexact_q <= inexact_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        shift_d   = shift_q;
        zero_d    = zero_q;
        data_d    = data_q;
        inexact_d = inexact_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mag_d   = in_data;
                    state_d = S_ABS;
                end
            end
            S_ABS: begin
                sign_d  = mag_q[XLEN-1];
                mag_d   = mag_q[XLEN-1] ? -mag_q : mag_q;
                shift_d = '0;
                zero_d  = (mag_q == '0);
                // A zero operand skips normalization but still passes through
                // ROUND so its result appears two edges after acceptance.
                state_d = (mag_q == '0) ? S_ROUND : S_NORM;
            end
            S_NORM: begin
                if (mag_q[XLEN-1]) begin
                    state_d = S_ROUND;
                end else begin
                    mag_d   = mag_q << 1;
                    shift_d = shift_q + 5'd1;
                end
            end
            S_ROUND: begin
                data_d    = zero_q ? '0 : w_pack_data;
                inexact_d = ~zero_q & w_pack_inexact;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign out_data    = data_q;
    assign out_inexact = inexact_q;

endmodule : fixed_to_fp

`default_nettype wire
